// File: rtl/mul_seq_unit_if.sv
// mul_seq_unit_if: operand/result bundle between the CPU register file and the sequential multiplier
//   start       - request a multiply (CPU -> multiplier)
//   opA, opB    - multiplicand / multiplier from source register Out buses
//   busy        - multiplier is in RUN or DONE
//   done        - one-cycle pulse while the product is presented
//   writeEnable - result register write strobe, same timing as done
//   resultLo/Hi - low/high halves of the product, to result register In buses
interface mul_seq_unit_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             busy;
    logic             done;
    logic             writeEnable;
    logic [WIDTH-1:0] resultLo;
    logic [WIDTH-1:0] resultHi;
    modport master (output start, opA, opB, input busy, done, writeEnable, resultLo, resultHi);
    modport slave  (input start, opA, opB, output busy, done, writeEnable, resultLo, resultHi);
endinterface

// File: rtl/mul_seq_unit.sv
// mul_seq_unit: multi-cycle shift-and-add unsigned multiplier (WIDTH x WIDTH -> 2*WIDTH)
//   clk   - system clock, all state changes on its rising edge
//   reset - asynchronous active-high reset, abandons any multiply in flight
//   bus   - mul_seq_unit_if.slave: start/opA/opB in, busy/done/writeEnable/resultLo/resultHi out
// Optional macro MUL_EARLY_TERM_EN: stop iterating once the remaining multiplier bits are all zero.
module mul_seq_unit #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    mul_seq_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   mcand, mplier, mplier_nx, res_lo, res_hi;
    logic [2*WIDTH-1:0] acc, acc_nx, prod;
    logic [WIDTH:0]     sum;
    logic [CW-1:0]      cnt, cnt_nx;
    logic               last;

    // One iteration: add into the upper half, then shift right with the carry entering the top bit.
    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_nx    = (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> 1);
        mplier_nx = mplier >> 1;
        cnt_nx    = cnt - CW'(1);
`ifdef MUL_EARLY_TERM_EN
        // Finishing early still needs the shifts of the skipped iterations, applied here at once.
        last      = (cnt_nx == '0) || (mplier_nx == '0);
        prod      = acc_nx >> cnt_nx;
`else
        last      = cnt_nx == '0;
        prod      = acc_nx;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (bus.start ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) : IDLE;
    end

    always_comb begin
        bus.busy        = state != IDLE;
        bus.done        = state == DONE;
        bus.writeEnable = state == DONE;
        bus.resultLo    = res_lo;
        bus.resultHi    = res_hi;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            res_lo <= '0;
            res_hi <= '0;
        end else if (state == IDLE && bus.start) begin
            mcand  <= bus.opA;
            mplier <= bus.opB;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
        end else if (state == RUN) begin
            mplier <= mplier_nx;
            acc    <= acc_nx;
            cnt    <= cnt_nx;
            // Result registers change only on the edge that enters DONE, then hold.
            if (last) {res_hi, res_lo} <= prod;
        end
    end
endmodule
